// File: rtl/systolic_feed_controller.sv
// rtl/systolic_feed_controller.sv - sequences one tile pass: operand reads, skewed lane masks, drain, done
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, base_addr    tile request from the scheduler; base_addr captured on accept
//   array_ready         skew stage / array accepts the current feed step
//   busy, done          pass in progress; one-cycle completion pulse
//   rd_en, rd_addr      operand buffer row read (rows base_addr .. base_addr+N-1)
//   lane_valid          per-lane skewed valid mask for the current feed step
//   clear_acc           accumulator clear on the first accepted feed step
//   step                current feed step index (0 outside FEED)
//   perf_stall_cycles   stalled FEED cycles of the last pass, saturating
//                       (present only when SYSTOLIC_FEED_PERF_EN is defined)
//
// Optional feature macro: SYSTOLIC_FEED_PERF_EN

module systolic_feed_controller #(
    parameter int MATRIX_SIZE  = 8,
    parameter int ADDR_BITS    = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int STEP_BITS    = $clog2(2 * MATRIX_SIZE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   base_addr,
    input  logic                   array_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_BITS-1:0]   rd_addr,
    output logic [MATRIX_SIZE-1:0] lane_valid,
    output logic                   clear_acc,
    output logic [STEP_BITS-1:0]   step
`ifdef SYSTOLIC_FEED_PERF_EN
    ,
    output logic [15:0]            perf_stall_cycles
`endif
);

    localparam int LAST_STEP  = 2 * MATRIX_SIZE - 2;
    localparam int DRAIN_BITS = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [STEP_BITS-1:0]  step_q;
    logic [DRAIN_BITS-1:0] drain_q;
    logic [ADDR_BITS-1:0]  base_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            step_q  <= '0;
            drain_q <= '0;
            base_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        step_q <= '0;
                    end
                end
                FEED: begin
                    if (array_ready) begin
                        if (step_q == STEP_BITS'(LAST_STEP)) begin
                            drain_q <= '0;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        lane_valid = '0;
        clear_acc  = 1'b0;
        step       = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FEED;
                end
            end
            FEED: begin
                step = step_q;
                // A stalled step drives nothing downstream; it is re-issued once accepted.
                if (array_ready) begin
                    rd_en     = (step_q < STEP_BITS'(MATRIX_SIZE));
                    rd_addr   = rd_en ? (base_q + ADDR_BITS'(step_q)) : '0;
                    clear_acc = (step_q == '0);
                    // Lane i sees its N operands on steps i .. i+N-1 (diagonal skew).
                    for (int i = 0; i < MATRIX_SIZE; i++) begin
                        lane_valid[i] = (int'(step_q) >= i) && (int'(step_q) <= i + MATRIX_SIZE - 1);
                    end
                    if (step_q == STEP_BITS'(LAST_STEP)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_BITS'(DRAIN_CYCLES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SYSTOLIC_FEED_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_stall_cycles <= '0;
        end else if (state == FEED && !array_ready && perf_stall_cycles != 16'hFFFF) begin
            perf_stall_cycles <= perf_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feed_controller.sv
// tb/tb_systolic_feed_controller.sv - scoreboard bench for systolic_feed_controller (N=4, DRAIN=4, ADDR=8)

module tb_systolic_feed_controller;

    localparam int N = 4;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic       array_ready;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [3:0] lane_valid;
    logic       clear_acc;
    logic [2:0] step;
`ifdef SYSTOLIC_FEED_PERF_EN
    logic [15:0] perf_stall_cycles;
`endif

    systolic_feed_controller #(
        .MATRIX_SIZE (N),
        .ADDR_BITS   (8),
        .DRAIN_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .array_ready(array_ready),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .lane_valid (lane_valid),
        .clear_acc  (clear_acc),
        .step       (step)
`ifdef SYSTOLIC_FEED_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic [3:0]  lane;
        logic        clear;
        logic [2:0]  step;
        logic [15:0] perf;
    } outs_t;

    outs_t exp_q[$];
    outs_t obs_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: 0 idle, 1 feed, 2 drain, 3 done
    int m_st    = 0;
    int m_step  = 0;
    int m_drain = 0;
    int m_base  = 0;
    int m_perf  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input logic s, input logic [7:0] b, input logic r, input logic rs, output outs_t o);
        outs_t e;
        @(negedge clock);
        start       = s;
        base_addr   = b;
        array_ready = r;
        reset       = rs;
        e = '0;
        e.busy = (m_st != 0);
        e.done = (m_st == 3);
        e.perf = 16'(m_perf);
        if (m_st == 1) begin
            e.step = 3'(m_step);
            if (r) begin
                e.rd_en   = (m_step < N);
                e.rd_addr = e.rd_en ? 8'((m_base + m_step) % 256) : 8'h00;
                e.clear   = (m_step == 0);
                for (int i = 0; i < N; i++) e.lane[i] = (m_step >= i) && (m_step <= i + N - 1);
            end
        end
`ifndef SYSTOLIC_FEED_PERF_EN
        e.perf = 16'h0;
`endif
        exp_q.push_back(e);
        if (rs) begin
            m_st = 0; m_step = 0; m_drain = 0; m_base = 0; m_perf = 0;
        end else begin
            case (m_st)
                0: if (s) begin m_st = 1; m_step = 0; m_base = b; m_perf = 0; end
                1: begin
                    if (r) begin
                        if (m_step == 2 * N - 2) begin m_st = 2; m_drain = 0; end
                        else m_step++;
                    end else if (m_perf < 65535) m_perf++;
                end
                2: if (m_drain == 3) m_st = 3; else m_drain++;
                default: m_st = 0;
            endcase
        end
        #1;
        o.busy    = busy;
        o.done    = done;
        o.rd_en   = rd_en;
        o.rd_addr = rd_addr;
        o.lane    = lane_valid;
        o.clear   = clear_acc;
        o.step    = step;
`ifdef SYSTOLIC_FEED_PERF_EN
        o.perf    = perf_stall_cycles;
`else
        o.perf    = 16'h0;
`endif
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        outs_t o, e;
        int k = 0;
        reset = 1'b1; start = 1'b0; base_addr = 8'h00; array_ready = 1'b0;
        repeat (2) @(posedge clock);
        tick(1'b0, 8'h00, 1'b0, 1'b1, o);
        n_cmp++;
        if (o !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", o); end
        tick(1'b1, 8'h55, 1'b1, 1'b1, o);
        tick(1'b0, 8'h00, 1'b1, 1'b0, o);
        n_cmp++;
        if (o.busy !== 1'b0) begin n_err++; $display("FAIL reset_ignores_start busy=%b exp=0", o.busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset_trace k=%0d got=%h exp=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_basic();
        outs_t o, e;
        logic [7:0] addrs[$];
        logic [3:0] lexp[7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        int done_cyc = -1, done_cnt = 0, clr_cnt = 0, clr_cyc = -1, busy_bad = 0, k = 0;
        for (int c = 0; c <= 13; c++) begin
            tick(c == 0, 8'h10, 1'b1, 1'b0, o);
            if (o.rd_en) addrs.push_back(o.rd_addr);
            if (o.done) begin done_cyc = c; done_cnt++; end
            if (o.clear) begin clr_cyc = c; clr_cnt++; end
            if (o.busy !== (c >= 1 && c <= 12)) busy_bad++;
            if (c >= 1 && c <= 7) begin
                n_cmp++;
                if (o.lane !== lexp[c-1]) begin n_err++; $display("FAIL basic_lane c=%0d got=%b exp=%b", c, o.lane, lexp[c-1]); end
            end
        end
        n_cmp++;
        if (addrs.size() != 4 || addrs[0] !== 8'h10 || addrs[1] !== 8'h11 || addrs[2] !== 8'h12 || addrs[3] !== 8'h13) begin
            n_err++; $display("FAIL basic_addrs got=%p exp=10,11,12,13", addrs);
        end
        n_cmp++;
        if (done_cyc != 12 || done_cnt != 1) begin n_err++; $display("FAIL basic_done cyc=%0d cnt=%0d exp=12/1", done_cyc, done_cnt); end
        n_cmp++;
        if (clr_cyc != 1 || clr_cnt != 1) begin n_err++; $display("FAIL basic_clear cyc=%0d cnt=%0d exp=1/1", clr_cyc, clr_cnt); end
        n_cmp++;
        if (busy_bad != 0) begin n_err++; $display("FAIL basic_busy bad_cycles=%0d exp=0", busy_bad); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL basic_trace k=%0d got=%h exp=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_stall();
        outs_t o, e;
        int done_cyc = -1, k = 0;
        for (int c = 0; c <= 15; c++) begin
            tick(c == 0, 8'h20, !(c == 3 || c == 4), 1'b0, o);
            if (o.done) done_cyc = c;
            if (c == 3 || c == 4) begin
                n_cmp++;
                if (o.step !== 3'd2 || o.rd_en !== 1'b0 || o.lane !== 4'b0000)
                    begin n_err++; $display("FAIL stall_hold c=%0d step=%0d rd_en=%b lane=%b exp=2/0/0000", c, o.step, o.rd_en, o.lane); end
            end
            if (c == 5) begin
                n_cmp++;
                if (o.rd_en !== 1'b1 || o.rd_addr !== 8'h22)
                    begin n_err++; $display("FAIL stall_resume rd_en=%b addr=%h exp=1/22", o.rd_en, o.rd_addr); end
            end
`ifdef SYSTOLIC_FEED_PERF_EN
            if (c == 15) begin
                n_cmp++;
                if (o.perf !== 16'd2) begin n_err++; $display("FAIL stall_perf got=%0d exp=2", o.perf); end
            end
`endif
        end
        n_cmp++;
        if (done_cyc != 14) begin n_err++; $display("FAIL stall_done cyc=%0d exp=14", done_cyc); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL stall_trace k=%0d got=%h exp=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_wrap();
        outs_t o, e;
        logic [7:0] addrs[$];
        int k = 0;
        for (int c = 0; c <= 13; c++) begin
            tick(c == 0, 8'hFE, 1'b1, 1'b0, o);
            if (o.rd_en) addrs.push_back(o.rd_addr);
        end
        n_cmp++;
        if (addrs.size() != 4 || addrs[0] !== 8'hFE || addrs[1] !== 8'hFF || addrs[2] !== 8'h00 || addrs[3] !== 8'h01) begin
            n_err++; $display("FAIL wrap_addrs got=%p exp=fe,ff,00,01", addrs);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL wrap_trace k=%0d got=%h exp=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        outs_t o, e;
        int dones[$];
        int k = 0;
        for (int c = 0; c <= 26; c++) begin
            tick(c == 0 || c == 3 || c == 12 || c == 13, 8'h30, 1'b1, 1'b0, o);
            if (o.done) dones.push_back(c);
            if (c == 13) begin
                n_cmp++;
                if (o.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap busy=%b exp=0", o.busy); end
            end
            if (c == 14) begin
                n_cmp++;
                if (o.busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_busy busy=%b exp=1", o.busy); end
            end
        end
        n_cmp++;
        if (dones.size() != 2 || dones[0] != 12 || dones[1] != 25) begin
            n_err++; $display("FAIL b2b_dones got=%p exp=12,25", dones);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL b2b_trace k=%0d got=%h exp=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_reset_mid();
        outs_t o, e;
        int done_cnt = 0, done_cyc = -1, k = 0;
        for (int c = 0; c <= 10; c++) begin
            tick(c == 0, 8'h40, 1'b1, c == 5, o);
            if (o.done) done_cnt++;
            if (c == 6) begin
                n_cmp++;
                if (o !== '0) begin n_err++; $display("FAIL midreset_outputs got=%h exp=0", o); end
            end
        end
        n_cmp++;
        if (done_cnt != 0) begin n_err++; $display("FAIL midreset_no_done cnt=%0d exp=0", done_cnt); end
        for (int c = 0; c <= 13; c++) begin
            tick(c == 0, 8'h44, 1'b1, 1'b0, o);
            if (o.done) done_cyc = c;
        end
        n_cmp++;
        if (done_cyc != 12) begin n_err++; $display("FAIL midreset_rerun_done cyc=%0d exp=12", done_cyc); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL midreset_trace k=%0d got=%h exp=%h", k, o, e); end
            k++;
        end
    endtask

`ifdef SYSTOLIC_FEED_PERF_EN
    task automatic test_perf_saturation();
        outs_t o, e;
        int done_cyc = -1, bad = 0;
        tick(1'b1, 8'h50, 1'b1, 1'b0, o);
        for (int c = 0; c < 70000; c++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, o);
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL perf_sat_trace bad_cycles=%0d exp=0", bad); end
        tick(1'b0, 8'h00, 1'b0, 1'b0, o);
        n_cmp++;
        if (o.perf !== 16'hFFFF) begin n_err++; $display("FAIL perf_sat_value got=%h exp=ffff", o.perf); end
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, o);
            if (o.done && done_cyc < 0) done_cyc = c;
        end
        n_cmp++;
        if (done_cyc < 0 || o.perf !== 16'hFFFF) begin n_err++; $display("FAIL perf_sat_release done_cyc=%0d perf=%h exp=done/ffff", done_cyc, o.perf); end
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef SYSTOLIC_FEED_PERF_EN
        test_perf_saturation();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
